// File: rtl/crc_tx_serializer.sv
// rtl/crc_tx_serializer.sv - byte-to-bit serializer feeding the serial LFSR CRC stage
// Payload bits go out LSB-first under ser_active, then a CRC_WIDTH shift-out window, then a done cycle.
module crc_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int CRC_WIDTH  = 8,
   parameter int MAX_BYTES  = 16,
   localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  ser_data,
   output logic                  ser_active,
   output logic                  crc_phase,
   output logic                  frame_done,
   output logic [LEN_W-1:0]      frame_len,
   output logic                  underrun_err,
   output logic                  len_err
);

   localparam int CNT_MAX = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_WIDTH - 1);
   localparam logic [LEN_W-1:0] MAX_B    = LEN_W'(MAX_BYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_CRC,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      byte_q, byte_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  last_q, last_d;
   logic                  under_q, under_d;
   logic                  lenerr_q, lenerr_d;

   logic bit_end;
   logic xfer;

   assign bit_end = (cnt_q == BIT_LAST);

   // A next word is only taken on the final bit of the current one, so the stream stays gap-free.
   assign in_ready = !rst && ((state_q == S_IDLE) ||
                              ((state_q == S_SHIFT) && bit_end && !last_q && (byte_q < MAX_B)));
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      len_d    = len_q;
      last_d   = last_q;
      under_d  = 1'b0;
      lenerr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               shreg_d = in_data;
               last_d  = in_last;
               byte_d  = LEN_W'(1);
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (xfer) begin
                  shreg_d = in_data;
                  last_d  = in_last;
                  byte_d  = byte_q + LEN_W'(1);
               end else begin
                  state_d = S_CRC;
                  if (!last_q) begin
                     if (byte_q == MAX_B) lenerr_d = 1'b1;
                     else                 under_d  = 1'b1;
                  end
               end
            end
         end
         S_CRC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CRC_LAST) begin
               cnt_d   = '0;
               len_d   = byte_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         byte_q   <= '0;
         len_q    <= '0;
         last_q   <= 1'b0;
         under_q  <= 1'b0;
         lenerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         len_q    <= len_d;
         last_q   <= last_d;
         under_q  <= under_d;
         lenerr_q <= lenerr_d;
      end
   end

   assign ser_active   = (state_q == S_SHIFT);
   assign ser_data     = ser_active && shreg_q[0];
   assign crc_phase    = (state_q == S_CRC);
   assign frame_done   = (state_q == S_DONE);
   assign frame_len    = len_q;
   assign underrun_err = under_q;
   assign len_err      = lenerr_q;

endmodule

// File: tb/tb_crc_tx_serializer.sv
// tb/tb_crc_tx_serializer.sv - randomized self-checking bench for crc_tx_serializer
// Expected traces are derived per frame from the word list and the frame-end rule.
module tb_crc_tx_serializer;

   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int MAXB  = 16;
   localparam int LEN_W = $clog2(MAXB + 1);

   localparam int M_LAST  = 0;
   localparam int M_UNDER = 1;
   localparam int M_LEN   = 2;

   logic             clk;
   logic             rst;
   logic [DW-1:0]    in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             ser_data;
   logic             ser_active;
   logic             crc_phase;
   logic             frame_done;
   logic [LEN_W-1:0] frame_len;
   logic             underrun_err;
   logic             len_err;

   int checks;
   int errors;
   int prev_len;
   int cyc;
   logic [DW-1:0] words [MAXB];

   crc_tx_serializer #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .MAX_BYTES(MAXB)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .ser_data     (ser_data),
      .ser_active   (ser_active),
      .crc_phase    (crc_phase),
      .frame_done   (frame_done),
      .frame_len    (frame_len),
      .underrun_err (underrun_err),
      .len_err      (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic fill_words();
      for (int i = 0; i < MAXB; i++) words[i] = DW'($urandom);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready",  32'(in_ready),     32'd0);
      check("rst_active", 32'(ser_active),   32'd0);
      check("rst_data",   32'(ser_data),     32'd0);
      check("rst_crc",    32'(crc_phase),    32'd0);
      check("rst_done",   32'(frame_done),   32'd0);
      check("rst_len",    32'(frame_len),    32'd0);
      check("rst_under",  32'(underrun_err), 32'd0);
      check("rst_lenerr", 32'(len_err),      32'd0);
   endtask

   // Entered just after a rising edge with the DUT idle; leaves just after a rising edge.
   // m_in is the number of words offered (ignored for the truncation mode).
   task automatic run_frame(input int mode, input int m_in, input int abort_at);
      int m, t_done, w, b;
      logic is_last_w, e_act, e_dat, e_rdy;
      m      = (mode == M_LEN) ? MAXB : m_in;
      t_done = DW * m + CW + 1;
      for (int t = 0; t <= t_done; t++) begin
         cyc = t;
         rst = (t == abort_at);
         if (t % DW == 0 && t / DW < m) begin
            in_valid = 1'b1;
            in_data  = words[t / DW];
            in_last  = (mode == M_LAST) && (t / DW == m - 1);
         end else if (t == DW * m && mode == M_UNDER) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
         end else if (t == DW * m && mode == M_LEN) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = 1'b0;
         end else begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
         end
         @(negedge clk);
         e_act     = (t >= 1) && (t <= DW * m);
         w         = (t - 1) / DW;
         b         = (t - 1) % DW;
         e_dat     = 1'b0;
         e_rdy     = (t == 0);
         if (e_act) begin
            is_last_w = (mode == M_LAST) && (w == m - 1);
            e_dat     = words[w][b];
            e_rdy     = (b == DW - 1) && !is_last_w && (w + 1 < MAXB);
         end
         if (t == abort_at) e_rdy = 1'b0;
         check("in_ready",     32'(in_ready),     32'(e_rdy));
         check("ser_active",   32'(ser_active),   32'(e_act));
         check("ser_data",     32'(ser_data),     32'(e_dat));
         check("crc_phase",    32'(crc_phase),    32'((t > DW * m) && (t <= DW * m + CW)));
         check("frame_done",   32'(frame_done),   32'(t == t_done));
         check("frame_len",    32'(frame_len),    32'((t == t_done) ? m : prev_len));
         check("underrun_err", 32'(underrun_err), 32'((t == DW * m + 1) && mode == M_UNDER));
         check("len_err",      32'(len_err),      32'((t == DW * m + 1) && mode == M_LEN));
         @(posedge clk);
         #1;
         if (t == abort_at) return;
      end
      prev_len = m;
   endtask

   initial begin
      int mode, n;
      checks   = 0;
      errors   = 0;
      prev_len = 0;
      cyc      = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      in_last  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single 0xA5 frame
      fill_words();
      words[0] = 8'hA5;
      run_frame(M_LAST, 1, -1);

      // three back-to-back words
      words[0] = 8'h01;
      words[1] = 8'h80;
      words[2] = 8'hFF;
      run_frame(M_LAST, 3, -1);

      // second word withheld
      fill_words();
      run_frame(M_UNDER, 1, -1);

      // truncated at MAX_BYTES
      fill_words();
      run_frame(M_LEN, MAXB, -1);

      // reset during bit 4 of word 2, then a clean single-word frame
      fill_words();
      run_frame(M_LAST, 3, DW + 5);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      prev_len = 0;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready),   32'd1);
      check("post_rst_done",  32'(frame_done), 32'd0);
      @(posedge clk);
      #1;
      words[0] = 8'hA5;
      run_frame(M_LAST, 1, -1);

      for (int f = 0; f < 30; f++) begin
         fill_words();
         mode = $urandom_range(0, 2);
         if (mode == M_LAST)       n = $urandom_range(1, MAXB);
         else if (mode == M_UNDER) n = $urandom_range(1, MAXB - 1);
         else                      n = MAXB;
         run_frame(mode, n, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
